seq_multiplier: RTL and testbench

Parametrised, multi-cycle shift-add multiplier with valid/ready handshakes on both sides and a run-time signed/unsigned mode. It is the registered successor to the ALU's combinational 16-bit multiply path. It trades WIDTH+1 cycles of latency for one adder of width WIDTH. It sits behind the ALU operand registers and feeds the ALU result mux.

---
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes and run-time signed mode.
// Operates on magnitudes and applies the sign once at the end, so one WIDTH-bit adder suffices.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    // Negating the most negative value wraps back to itself, which reads as 2^(WIDTH-1) unsigned.
    a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        // Carry-out of the add lands in the top bit after the right shift.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        p_d     = neg_q ? -acc_q : acc_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCalc) || (state_q == StFix);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, scoreboard monitor and hand-written
// sequences for latency, backpressure, mid-operation reset and the 8-bit variant.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] p;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                           input logic sm);
    logic signed [31:0] sx, sy;
    if (sm) begin
      sx = {{16{x[15]}}, x};
      sy = {{16{y[15]}}, y};
      return 32'(sx * sy);
    end
    return {16'd0, x} * {16'd0, y};
  endfunction

  // Scoreboard: compare each delivered product against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got p=0x%0h with nothing pending", p);
        end else begin
          check("product", 64'(p), 64'(sb.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic sm,
                       input logic [31:0] exp, output int acc_cyc);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles, expected 1", k);
      acc_cyc = -1;
      return;
    end
    a = x; b = y; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    sb.push_back(exp);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic drain(input bit stall);
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_lat(input logic [15:0] x, input logic [15:0] y, input logic sm,
                         input logic [31:0] exp);
    int ac;
    int lat = 0;
    int bcnt = 0;
    out_ready = 1'b1;
    issue(x, y, sm, exp, ac);
    for (int k = 1; k <= 40; k++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'd17);
    check("busy_cycles", 64'(bcnt), 64'd17);
    check("lat_product", 64'(p), 64'(exp));
    @(posedge clk); #1;
    check("ready_after_handshake", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int ac, prev, k;
    logic [31:0] exp;
    logic [15:0] x, y;
    logic        sm;

    vecs[0] = '{16'h0475, 16'h5976, 1'b0, 32'h018E_BAEE};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vecs[6] = '{16'h0000, 16'h8000, 1'b1, 32'h0000_0000};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001};
    vecs[9] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1};

    in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_lat(16'h0475, 16'h5976, 1'b0, 32'h018E_BAEE);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, ac);
      drain(1'b0);
    end

    // Backpressure, with in_valid pulses and operand changes while busy and while done.
    out_ready = 1'b0;
    exp = ref_prod(16'h1234, 16'h5678, 1'b0);
    issue(16'h1234, 16'h5678, 1'b0, exp, ac);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; a = 16'h0BAD; b = 16'hBEEF;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 2 || i == 3);
      @(posedge clk); #1;
      check("bp_p_stable", 64'(p), 64'(exp));
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    drain(1'b0);
    check("bp_idle_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("bp_no_requeue", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges during CALC iteration 8.
    issue(16'h00FF, 16'h00FF, 1'b0, ref_prod(16'h00FF, 16'h00FF, 1'b0), ac);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_p", 64'(p), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_lat(16'd3, 16'd5, 1'b0, 32'd15);

    // Back-to-back with out_ready tied high: accepts should be exactly 19 cycles apart.
    out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom); y = 16'($urandom); sm = 1'($urandom);
      issue(x, y, sm, ref_prod(x, y, sm), ac);
      if (prev >= 0) check("issue_interval", 64'(ac - prev), 64'd19);
      prev = ac;
    end
    drain(1'b0);

    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom); y = 16'($urandom); sm = 1'($urandom);
      issue(x, y, sm, ref_prod(x, y, sm), ac);
      drain(1'b1);
    end

    // WIDTH=8 instance.
    for (int i = 0; i < 2; i++) begin
      a8 = (i == 0) ? 8'h80 : 8'hFF;
      b8 = (i == 0) ? 8'h80 : 8'h02;
      sm8 = 1'b1;
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      check("w8_busy", 64'(busy8), 64'd1);
      k = 0;
      for (int j = 1; j <= 30; j++) begin
        @(posedge clk); #1;
        if (out_valid8) begin
          k = j;
          break;
        end
      end
      check("w8_latency", 64'(k), 64'd9);
      check("w8_product", 64'(p8), (i == 0) ? 64'h4000 : 64'hFFFE);
      @(posedge clk); #1;
      check("w8_ready", 64'(in_ready8), 64'd1);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
